// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the pad bank direction controller.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_IDLE = 2'd0,
        TGT_RX   = 2'd1,
        TGT_TX   = 2'd2
    } target_t;

    // Bit positions inside the {SR, DS1, DS0} configuration word
    localparam int CFG_DS0 = 0;
    localparam int CFG_DS1 = 1;
    localparam int CFG_SR  = 2;

    // Largest legal turnaround length and burst cap; one counter width covers both
    localparam int TURN_LIMIT  = 15;
    localparam int BURST_LIMIT = 255;
    localparam int CNT_W = $clog2(((TURN_LIMIT > BURST_LIMIT) ? TURN_LIMIT : BURST_LIMIT) + 1);

    // Maps a turnaround target onto the state entered once the dead cycles expire
    function automatic state_t target_state(input target_t t);
        case (t)
            TGT_RX:  return ST_RX;
            TGT_TX:  return ST_TX;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Two-flop synchronizer for pad input data plus its valid tag.
module pad_in_sync #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First flop may go metastable; the second gives it a full cycle to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_bank_dir_ctrl.sv
// Direction/config controller sharing a bidirectional pad bank between TX and RX.
module pad_bank_dir_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int         WIDTH       = 8,
    parameter int         TURN_CYCLES = 2,
    parameter int         MAX_BURST   = 16,
    parameter logic [2:0] CFG_RST     = 3'b011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_req,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_wdata,
    output logic             busy,
    output logic [WIDTH-1:0] pad_a,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_ie,
    output logic             pad_ds0,
    output logic             pad_ds1,
    output logic             pad_sr,
    input  logic [WIDTH-1:0] pad_y
);

    state_t           state, state_next;
    target_t          target, target_next;
    logic [CNT_W-1:0] turn_cnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             turn_done;
    logic             burst_last;
    logic             beat;
    logic             enter_idle;
    logic             ie_prev;
    logic [2:0]       cfg;
    logic [2:0]       pend_val;
    logic             pend;
    logic [WIDTH:0]   sync_in;
    logic [WIDTH:0]   sync_out;

    assign turn_done  = (turn_cnt == CNT_W'(TURN_CYCLES - 1));
    assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign tx_ready   = (state == ST_TX) && (burst_cnt < CNT_W'(MAX_BURST));
    assign beat       = tx_valid && tx_ready;
    assign busy       = (state != ST_IDLE);
    assign enter_idle = (state != ST_IDLE) && (state_next == ST_IDLE);

    // Next-state selection; TX wins over RX and every direction change goes through TURN
    always_comb begin
        state_next  = state;
        target_next = target;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_next  = ST_TURN;
                    target_next = TGT_TX;
                end else if (rx_req) begin
                    state_next  = ST_TURN;
                    target_next = TGT_RX;
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    state_next = target_state(target);
                end
            end
            ST_RX: begin
                if (tx_valid) begin
                    state_next  = ST_TURN;
                    target_next = TGT_TX;
                end else if (!rx_req) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TX: begin
                if (beat && rx_req && burst_last) begin
                    state_next  = ST_TURN;
                    target_next = TGT_RX;
                end else if (!tx_valid && rx_req) begin
                    state_next  = ST_TURN;
                    target_next = TGT_RX;
                end else if (!tx_valid) begin
                    state_next  = ST_TURN;
                    target_next = TGT_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and turnaround target registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            target <= TGT_IDLE;
        end else begin
            state  <= state_next;
            target <= target_next;
        end
    end

    // Dead-cycle counter restarts on every entry into TURN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt <= '0;
        end else if ((state != ST_TURN) && (state_next == ST_TURN)) begin
            turn_cnt <= '0;
        end else if (state == ST_TURN) begin
            turn_cnt <= turn_cnt + 1'b1;
        end
    end

    // Burst counter only advances on beats taken while RX is waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if ((state != ST_TX) && (state_next == ST_TX)) begin
            burst_cnt <= '0;
        end else if (beat && rx_req) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Registered pad enables follow the state being entered, so they never overlap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_oe  <= '0;
            pad_ie  <= '0;
            ie_prev <= 1'b0;
        end else begin
            pad_oe  <= {WIDTH{state_next == ST_TX}};
            pad_ie  <= {WIDTH{state_next == ST_RX}};
            ie_prev <= pad_ie[0];
        end
    end

    // Output data register loads only on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_a <= '0;
        end else if (beat) begin
            pad_a <= tx_data;
        end
    end

    // Config is applied only when both enables are low; a write landing on the IDLE entry edge wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg      <= CFG_RST;
            pend_val <= '0;
            pend     <= 1'b0;
        end else if (enter_idle) begin
            if (cfg_we) begin
                cfg <= cfg_wdata;
            end else if (pend) begin
                cfg <= pend_val;
            end
            pend <= 1'b0;
        end else if (cfg_we) begin
            if (state == ST_IDLE) begin
                cfg <= cfg_wdata;
            end else begin
                pend_val <= cfg_wdata;
                pend     <= 1'b1;
            end
        end
    end

    assign pad_ds0 = cfg[CFG_DS0];
    assign pad_ds1 = cfg[CFG_DS1];
    assign pad_sr  = cfg[CFG_SR];

    // The tag marks samples taken after IE has been high for a full settling cycle
    assign sync_in = {pad_ie[0] & ie_prev, pad_y};

    pad_in_sync #(
        .W (WIDTH + 1)
    ) u_in_sync (
        .clk (clk),
        .rst (rst),
        .d   (sync_in),
        .q   (sync_out)
    );

    assign rx_valid = sync_out[WIDTH];
    assign rx_data  = sync_out[WIDTH-1:0];

endmodule

// File: tb/tb_pad_bank_dir_ctrl.sv
// Self-checking bench for pad_bank_dir_ctrl with a behavioural reference model.
module tb_pad_bank_dir_ctrl;

    localparam int         WIDTH       = 8;
    localparam int         TURN_CYCLES = 2;
    localparam int         MAX_BURST   = 16;
    localparam logic [2:0] CFG_RST     = 3'b011;

    localparam int M_IDLE = 0;
    localparam int M_RX   = 1;
    localparam int M_TX   = 2;
    localparam int M_DEAD = 3;

    logic             clk;
    logic             rst;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             cfg_we;
    logic [2:0]       cfg_wdata;
    logic             busy;
    logic [WIDTH-1:0] pad_a;
    logic [WIDTH-1:0] pad_oe;
    logic [WIDTH-1:0] pad_ie;
    logic             pad_ds0;
    logic             pad_ds1;
    logic             pad_sr;
    logic [WIDTH-1:0] pad_y;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             m_mode;
    int             m_goal;
    int             m_left;
    int             m_beats;
    logic           m_oe;
    logic           m_ie;
    logic           m_ie_prev;
    logic [WIDTH-1:0] m_a;
    logic [2:0]     m_cfg;
    logic [2:0]     m_pend;
    bit             m_pend_v;
    logic [WIDTH:0] rx_q[$];
    logic [WIDTH:0] m_rx;

    pad_bank_dir_ctrl #(
        .WIDTH       (WIDTH),
        .TURN_CYCLES (TURN_CYCLES),
        .MAX_BURST   (MAX_BURST),
        .CFG_RST     (CFG_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_req    (rx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .busy      (busy),
        .pad_a     (pad_a),
        .pad_oe    (pad_oe),
        .pad_ie    (pad_ie),
        .pad_ds0   (pad_ds0),
        .pad_ds1   (pad_ds1),
        .pad_sr    (pad_sr),
        .pad_y     (pad_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic tv, input logic [WIDTH-1:0] td, input logic rq,
                                 input logic [WIDTH-1:0] py, input logic cw, input logic [2:0] cd);
        tx_valid  = tv;
        tx_data   = td;
        rx_req    = rq;
        pad_y     = py;
        cfg_we    = cw;
        cfg_wdata = cd;
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_goal    = M_IDLE;
        m_left    = 0;
        m_beats   = 0;
        m_oe      = 1'b0;
        m_ie      = 1'b0;
        m_ie_prev = 1'b0;
        m_a       = '0;
        m_cfg     = CFG_RST;
        m_pend    = '0;
        m_pend_v  = 1'b0;
        rx_q.delete();
        rx_q.push_back('0);
        m_rx      = '0;
    endtask

    function automatic logic m_tx_ready();
        return (m_mode == M_TX) && (m_beats < MAX_BURST);
    endfunction

    task automatic go_dead(inout int nm, input int goal);
        nm     = M_DEAD;
        m_goal = goal;
        m_left = TURN_CYCLES;
    endtask

    // One clock edge of the specification's behaviour, using pre-edge inputs and model state
    task automatic model_edge();
        logic beat;
        int   old;
        int   nm;
        beat = tx_valid && m_tx_ready();
        old  = m_mode;
        nm   = m_mode;

        rx_q.push_back({m_ie & m_ie_prev, pad_y});
        m_rx      = rx_q.pop_front();
        m_ie_prev = m_ie;

        case (old)
            M_IDLE: begin
                if (tx_valid) go_dead(nm, M_TX);
                else if (rx_req) go_dead(nm, M_RX);
            end
            M_DEAD: begin
                m_left--;
                if (m_left == 0) begin
                    nm = m_goal;
                    if (nm == M_TX) m_beats = 0;
                end
            end
            M_RX: begin
                if (tx_valid) go_dead(nm, M_TX);
                else if (!rx_req) nm = M_IDLE;
            end
            default: begin
                if (beat) begin
                    m_a = tx_data;
                    if (rx_req) m_beats++;
                end
                if (beat && rx_req && m_beats == MAX_BURST) go_dead(nm, M_RX);
                else if (!tx_valid && rx_req) go_dead(nm, M_RX);
                else if (!tx_valid) go_dead(nm, M_IDLE);
            end
        endcase

        if (old != M_IDLE && nm == M_IDLE) begin
            if (cfg_we) m_cfg = cfg_wdata;
            else if (m_pend_v) m_cfg = m_pend;
            m_pend_v = 1'b0;
        end else if (cfg_we) begin
            if (old == M_IDLE) m_cfg = cfg_wdata;
            else begin
                m_pend   = cfg_wdata;
                m_pend_v = 1'b1;
            end
        end

        m_mode = nm;
        m_oe   = (nm == M_TX);
        m_ie   = (nm == M_RX);
    endtask

    task automatic checkAll();
        checkOutput("pad_oe",   pad_oe,   {WIDTH{m_oe}});
        checkOutput("pad_ie",   pad_ie,   {WIDTH{m_ie}});
        checkOutput("pad_a",    pad_a,    m_a);
        checkOutput("tx_ready", tx_ready, m_tx_ready());
        checkOutput("busy",     busy,     m_mode != M_IDLE);
        checkOutput("rx_data",  rx_data,  m_rx[WIDTH-1:0]);
        checkOutput("rx_valid", rx_valid, m_rx[WIDTH]);
        checkOutput("cfg",      {pad_sr, pad_ds1, pad_ds0}, m_cfg);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        checkAll();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  m;
        int  nb;
        int  dead;
        int  cyc;
        bit  ie_seen;
        logic rq;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        model_reset();
        #2;
        checkOutput("rst_oe",  pad_oe, 8'h00);
        checkOutput("rst_cfg", {pad_sr, pad_ds1, pad_ds0}, 3'b011);
        checkAll();
        tick();
        tick();
        rst = 1'b0;

        // Plain TX of two words from IDLE
        applyStimulus(1'b1, 8'hA5, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("turn1_oe", pad_oe, 8'h00);
        tick();
        checkOutput("turn2_oe", pad_oe, 8'h00);
        tick();
        checkOutput("tx_oe", pad_oe, 8'hFF);
        checkOutput("tx_ready_on", tx_ready, 1);
        tick();
        checkOutput("pad_a_first", pad_a, 8'hA5);
        applyStimulus(1'b1, 8'h3C, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("pad_a_second", pad_a, 8'h3C);
        applyStimulus(1'b0, 8'h00, 1'b0, '0, 1'b0, '0);
        tick();
        checkOutput("tx_exit_oe", pad_oe, 8'h00);
        tick();
        tick();
        checkOutput("tx_idle_busy", busy, 0);

        // RX sampling with settling discard
        applyStimulus(1'b0, '0, 1'b1, 8'h5A, 1'b0, '0);
        n = 0;
        do begin
            tick();
            n++;
        end while (pad_ie[0] !== 1'b1 && n < 12);
        checkOutput("rx_ie_delay", n, 3);
        m = 0;
        do begin
            tick();
            m++;
        end while (rx_valid !== 1'b1 && m < 12);
        checkOutput("rx_valid_delay", m, 3);
        checkOutput("rx_data_5a", rx_data, 8'h5A);
        applyStimulus(1'b0, '0, 1'b0, 8'h5A, 1'b0, '0);
        tick();
        checkOutput("rx_leave_ie", pad_ie, 8'h00);
        checkOutput("rx_drain1", rx_valid, 1);
        tick();
        checkOutput("rx_drain2", rx_valid, 1);
        tick();
        checkOutput("rx_drain_end", rx_valid, 0);

        // Simultaneous requests choose TX, then the burst cap hands the bank to RX
        applyStimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0, '0);
        tick();
        tick();
        tick();
        checkOutput("both_req_oe", pad_oe, 8'hFF);
        checkOutput("both_req_ie", pad_ie, 8'h00);
        nb = 0;
        dead = 0;
        cyc = 0;
        ie_seen = 1'b0;
        while (!ie_seen && cyc < 80) begin
            if (tx_ready === 1'b1 && tx_valid) nb++;
            if (nb > 0 && pad_oe === 8'h00 && pad_ie === 8'h00) dead++;
            applyStimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0, '0);
            tick();
            cyc++;
            ie_seen = (pad_ie[0] === 1'b1);
        end
        checkOutput("burst_reached_rx", ie_seen, 1);
        checkOutput("burst_beats", nb, MAX_BURST);
        checkOutput("burst_dead", dead, TURN_CYCLES);
        applyStimulus(1'b1, 8'($urandom), 1'b0, 8'($urandom), 1'b0, '0);
        tick();
        checkOutput("resume_turn_ie", pad_ie, 8'h00);
        tick();
        tick();
        checkOutput("resume_tx_oe", pad_oe, 8'hFF);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        repeat (4) tick();

        // Config writes during TX are deferred to IDLE entry, last write wins
        applyStimulus(1'b1, 8'h11, 1'b0, '0, 1'b0, '0);
        repeat (3) tick();
        applyStimulus(1'b1, 8'h22, 1'b0, '0, 1'b1, 3'b100);
        tick();
        checkOutput("cfg_deferred1", {pad_sr, pad_ds1, pad_ds0}, 3'b011);
        applyStimulus(1'b1, 8'h33, 1'b0, '0, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 8'h44, 1'b0, '0, 1'b1, 3'b001);
        tick();
        checkOutput("cfg_deferred2", {pad_sr, pad_ds1, pad_ds0}, 3'b011);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        checkOutput("cfg_turn_hold", {pad_sr, pad_ds1, pad_ds0}, 3'b011);
        tick();
        checkOutput("cfg_idle_apply", {pad_sr, pad_ds1, pad_ds0}, 3'b001);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 3'b110);
        tick();
        checkOutput("cfg_idle_write", {pad_sr, pad_ds1, pad_ds0}, 3'b110);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick();

        // Asynchronous reset in the middle of TX with a pending config
        applyStimulus(1'b1, 8'hE7, 1'b0, '0, 1'b0, '0);
        repeat (3) tick();
        applyStimulus(1'b1, 8'hE7, 1'b0, '0, 1'b1, 3'b111);
        tick();
        checkOutput("pre_rst_a", pad_a, 8'hE7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("async_rst_oe", pad_oe, 8'h00);
        checkOutput("async_rst_ie", pad_ie, 8'h00);
        checkOutput("async_rst_a", pad_a, 8'h00);
        checkOutput("async_rst_cfg", {pad_sr, pad_ds1, pad_ds0}, 3'b011);
        checkAll();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_cfg", {pad_sr, pad_ds1, pad_ds0}, 3'b011);

        // Randomized traffic against the reference model
        rq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rq = ~rq;
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), rq, 8'($urandom),
                          ($urandom_range(0, 15) == 0), 3'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_bank_dir_ctrl.md
Name: pad_bank_dir_ctrl

Overview:
Direction and configuration controller for a bank of WIDTH bidirectional GF12 pads (PBIDIRN_18_18 H/V wrappers). It shares the bank between an output requester (TX stream) and an input requester (RX sampling). It enforces dead turnaround cycles between directions, caps TX bursts so RX is not starved, and owns the drive-strength/slew configuration driven onto DS0/DS1/SR. It sits between core-side I/O logic and the pad instances in the chip top.

Parameters:
WIDTH, 8, number of pads in the bank
TURN_CYCLES, 2, dead cycles with OE=0 and IE=0 on every direction change (legal range 1..15)
MAX_BURST, 16, maximum consecutive TX beats while rx_req is pending (legal range 1..255)
CFG_RST, 3'b011, reset value of {SR, DS1, DS0}

Ports:
clk  in  1  block clock
rst  in  1  asynchronous active-high reset
tx_valid  in  1  TX word available
tx_data  in  WIDTH  TX word
tx_ready  out  1  TX word accepted this cycle when tx_valid is also high
rx_req  in  1  request to sample the pads
rx_data  out  WIDTH  synchronized pad sample
rx_valid  out  1  rx_data qualifies
cfg_we  in  1  configuration write strobe
cfg_wdata  in  3  {SR, DS1, DS0}
busy  out  1  state is not IDLE
pad_a  out  WIDTH  to pad A
pad_oe  out  WIDTH  to pad OE (all bits equal)
pad_ie  out  WIDTH  to pad IE (all bits equal)
pad_ds0, pad_ds1, pad_sr  out  1 each  to every pad in the bank
pad_y  in  WIDTH  from pad Y (asynchronous)

Behaviour:
- Reset values: state IDLE; pad_oe=0, pad_ie=0, pad_a=0, rx_data=0, rx_valid=0, tx_ready=0, busy=0; {pad_sr, pad_ds1, pad_ds0}=CFG_RST; pending-config flag cleared; turn and burst counters cleared.
- States: IDLE, RX, TX, TURN.
- IDLE: OE=0, IE=0. If tx_valid, go to TURN with target TX. Else if rx_req, go to TURN with target RX. TX wins when both are requested.
- TURN: OE=0, IE=0 for exactly TURN_CYCLES cycles, then enter the target state. tx_ready=0 throughout.
- RX: IE=1, OE=0.
  - If tx_valid, go to TURN with target TX.
  - Else if !rx_req, go to IDLE with no turnaround.
- TX: OE=1, IE=0.
  - tx_ready = 1 when in TX and burst limit is not reached. This is combinational from registered state and counter, and never depends on tx_valid.
  - Each beat (tx_valid & tx_ready) registers tx_data into pad_a. pad_a holds its value otherwise.
  - Burst counter increments per beat while rx_req=1 and clears on TX entry.
  - Exit conditions, in priority order:
    1. Counter reaches MAX_BURST with rx_req=1: go to TURN with target RX. This beat is the last one accepted.
    2. tx_valid=0 and rx_req=1: go to TURN with target RX.
    3. tx_valid=0 and rx_req=0: go to TURN with target IDLE (OE drops).
- pad_oe and pad_ie are registered and change on the clock edge of the state transition. They are never both 1.
- RX path:
  - pad_y passes through a 2-flop synchronizer into rx_data.
  - A valid tag travels alongside the data. The tag is 1 for a sample captured while pad_ie was high in both the capture cycle and the previous cycle, so the first IE cycle is discarded for settling.
  - rx_data/rx_valid appear 2 cycles after capture.
  - On leaving RX, the in-flight tags drain normally, so the last 2 rx_valid pulses follow the state change.
- Config:
  - cfg_we in IDLE: apply cfg_wdata to the pad config outputs on the next edge.
  - cfg_we in any other state: store the value and set the pending flag. The pending value is applied on the edge that enters IDLE.
  - A later write overwrites the pending value.
  - Config never changes while OE or IE is high.
- busy = (state != IDLE).
- Reset asserted mid-operation immediately forces the reset values (asynchronous) and drops any pending config.

Decomposition:
- Shared package pad_ctrl_pkg: state enum, target enum, CFG field indices, and a TURN/burst counter-width constant derived from the parameter ranges.
- One sub-module, pad_in_sync: a WIDTH+1-bit 2-flop synchronizer carrying data plus the valid tag. It is reused by other pad banks.

Test Plan:
- Reset: assert rst mid-TX -> pad_oe=0, pad_ie=0, pad_a=0 and {sr,ds1,ds0}=3'b011 in the same cycle, with no clock edge needed.
- IDLE with tx_valid and data 8'hA5, 8'h3C -> 2 cycles of OE=0/IE=0, then OE=1. pad_a=8'hA5 then 8'h3C on consecutive cycles; tx_ready high 2 cycles.
- rx_req held with pad_y=8'h5A -> IE rises after 2 TURN cycles; first rx_valid appears 3 cycles after the IE rise with rx_data=8'h5A.
- Continuous tx_valid with rx_req=1 -> exactly 16 beats accepted, then 2 dead cycles, then IE=1. TX resumes via TURN once rx_req drops while tx_valid is still high.
- tx_valid and rx_req rising in the same cycle in IDLE -> target TX chosen; pad_ie stays 0.
- cfg_we=1 with 3'b100 during TX -> pad config unchanged until the edge entering IDLE, then 3'b100. A second write of 3'b001 before IDLE -> 3'b001 applied.
